// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an LSB-first 8N1 UART transmitter.
// Ports: clk, rst_n, tx_data/tx_valid/tx_ready, uart_tx, tx_busy, fifo_count; UART_TX_PARITY_EN adds even parity.
module uart_tx_fifo #(
  parameter int unsigned DELAY_FRAMES = 234,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] LAST = 16'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          avail_q;
  logic          busy_q;

  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic          push;
  logic          pop;
  logic          bit_end;
  logic          idle_next;
  logic [7:0]    head;

  assign tx_ready = (count_q != FULL);
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (cnt_q == LAST);
  assign head     = mem_q[rd_ptr_q];

  // IDLE looks at a registered non-empty flag, so a fresh byte
  // starts its frame two edges after the write.
  assign pop = ((state_q == S_IDLE) && avail_q) ||
               ((state_q == S_STOP) && bit_end && (count_q != '0));

  assign idle_next = ((state_q == S_IDLE) && !avail_q) ||
                     ((state_q == S_STOP) && bit_end && (count_q == '0));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      avail_q <= (count_q != '0);
      // Rises one edge after a push; drops on the edge the FSM idles.
      busy_q  <= !idle_next || (count_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (avail_q) begin
            state_q <= S_START;
            shift_q <= head;
            tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^head;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            // Chain straight into the next start bit, no idle gap.
            if (count_q != '0) begin
              state_q <= S_START;
              shift_q <= head;
              tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^head;
`endif
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Table of single frames plus burst, full-hold and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DF    = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DF;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .DELAY_FRAMES(DF),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected line level for bit slot b of a frame.
  function automatic logic fbit(input logic [7:0] d, input logic p,
                                input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && NB == 11) return p;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (!tx_busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", 32'(tx_busy), 0);
  endtask

  task automatic send_check(input logic [7:0] d, input logic p);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    chk($sformatf("acc_cnt_%0h", d), 32'(fifo_count), 1);
    chk($sformatf("acc_busy_%0h", d), 32'(tx_busy), 0);
    chk($sformatf("acc_tx_%0h", d), 32'(uart_tx), 1);
    @(negedge clk);
    chk($sformatf("k1_busy_%0h", d), 32'(tx_busy), 1);
    chk($sformatf("k1_tx_%0h", d), 32'(uart_tx), 1);
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < DF; c++) begin
        chk($sformatf("bit_%0h_%0d_%0d", d, b, c), 32'(uart_tx),
            32'(fbit(d, p, b)));
        @(negedge clk);
      end
    end
    chk($sformatf("end_busy_%0h", d), 32'(tx_busy), 0);
    chk($sformatf("end_tx_%0h", d), 32'(uart_tx), 1);
    chk($sformatf("end_cnt_%0h", d), 32'(fifo_count), 0);
  endtask

  task automatic burst();
    int exp_cnt[6];
    logic [7:0] by;
    int f;
    int b;
    exp_cnt = '{0, 1, 2, 2, 3, 4};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_ready_%0d", i), 32'(tx_ready), (i < 5) ? 1 : 0);
      chk($sformatf("burst_cnt_%0d", i), 32'(fifo_count), exp_cnt[i]);
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("burst_cnt_full", 32'(fifo_count), 4);
    for (int t = 3; t < 5 * FL; t++) begin
      f  = t / FL;
      b  = (t % FL) / DF;
      by = 8'(f);
      chk($sformatf("burst_bit_t%0d", t), 32'(uart_tx),
          32'(fbit(by, ^by, b)));
      if (t % FL == 0)
        chk($sformatf("burst_step_%0d", f), 32'(fifo_count), 4 - f);
      @(negedge clk);
    end
    chk("burst_end_busy", 32'(tx_busy), 0);
    chk("burst_end_tx", 32'(uart_tx), 1);
    chk("burst_end_cnt", 32'(fifo_count), 0);
  endtask

  task automatic full_hold();
    for (int i = 0; i < 5; i++) begin
      tx_data  = 8'(8'h10 + i);
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_data = 8'hEE;
    for (int t = 2; t < FL - 1; t++) @(negedge clk);
    chk("hold_pre_cnt", 32'(fifo_count), 4);
    chk("hold_pre_ready", 32'(tx_ready), 0);
    @(negedge clk);
    chk("hold_pop_cnt", 32'(fifo_count), 3);
    chk("hold_pop_ready", 32'(tx_ready), 1);
    @(negedge clk);
    chk("hold_push_cnt", 32'(fifo_count), 4);
    chk("hold_push_ready", 32'(tx_ready), 0);
    tx_valid = 1'b0;
    wait_idle(FL * 6 + 20);
    chk("hold_end_cnt", 32'(fifo_count), 0);
  endtask

  task automatic reset_mid();
    logic bad;
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h5A;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("rm_bit3_tx", 32'(uart_tx), 0);
    chk("rm_queued", 32'(fifo_count), 1);
    rst_n = 1'b0;
    #1;
    chk("rm_async_tx", 32'(uart_tx), 1);
    chk("rm_async_cnt", 32'(fifo_count), 0);
    chk("rm_async_busy", 32'(tx_busy), 0);
    chk("rm_async_ready", 32'(tx_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0)
        bad = 1'b1;
    end
    chk("rm_quiet_after", 32'(bad), 0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0};
    vecs[2] = '{8'h07, 1'b1};
    vecs[3] = '{8'h03, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h01, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 1);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_cnt", 32'(fifo_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send_check(vecs[v].data, vecs[v].par);
    end

    burst();
    @(negedge clk);
    full_hold();
    @(negedge clk);
    reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
